// File: rtl/fetch_pair_tracker_pkg.sv
// rtl/fetch_pair_tracker_pkg.sv - shared types and defaults for the fetch pair tracker
//
// Purpose: default width/depth constants and the {addr,data} fetch record type
//          shared by the tracker, its snoop interface and anything that
//          consumes paired fetch records.
package fetch_pair_tracker_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    // Paired fetch record at the default widths.
    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } fetch_rec_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_pair_tracker_if.sv
// rtl/fetch_pair_tracker_if.sv - snooped instruction fetch address/data bus
//
// Purpose: bundles the CPU instruction-fetch address and data handshakes.
// Modports:
//   master - the party that drives the fetch bus (CPU/memory side, or a bench)
//   slave  - a passive observer; every signal is an input
interface fetch_pair_tracker_if
    import fetch_pair_tracker_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  ir_addr_valid;
    logic                  ir_addr_ready;
    logic [ADDR_WIDTH-1:0] ir_addr;
    logic                  ir_data_valid;
    logic                  ir_data_ready;
    logic [DATA_WIDTH-1:0] ir_data;

    modport master (
        output ir_addr_valid,
        output ir_addr_ready,
        output ir_addr,
        output ir_data_valid,
        output ir_data_ready,
        output ir_data
    );

    modport slave (
        input ir_addr_valid,
        input ir_addr_ready,
        input ir_addr,
        input ir_data_valid,
        input ir_data_ready,
        input ir_data
    );

endinterface

// File: rtl/fetch_pair_tracker_sync_fifo.sv
// rtl/fetch_pair_tracker_sync_fifo.sv - generic synchronous first-word-fall-through FIFO
//
// Purpose: in-order storage with simultaneous push/pop. The head entry is
//          always visible on pop_data_o while not empty.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears pointers/count)
//   push_i       - write push_data_i; ignored when full unless popping same cycle
//   pop_i        - retire head entry; ignored when empty
//   pop_data_o   - current head entry
//   full_o, empty_o, count_o - occupancy status (count_o spans 0..DEPTH)
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural AW-bit overflow wraps the pointers.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_pair_tracker.sv
// rtl/fetch_pair_tracker.sv - pairs snooped fetch addresses with their returned data
//
// Purpose: passively watches an instruction-fetch bus, queues accepted fetch
//          addresses in order and, as each data beat is accepted, emits a
//          one-cycle-latency {addr,data} record. Flags overflow, orphan data
//          and dropped records (sticky until reset).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   ir            - snooped fetch bus (slave modport, inputs only)
//   out_valid/out_ready/out_addr/out_data - paired record output
//   outstanding   - addresses still waiting for data (0..DEPTH)
//   pair_count    - records produced since reset, wraps at 2^32
//   err_overflow  - address seen with the queue full and no pop
//   err_orphan    - data seen with no outstanding address
//   err_drop      - unconsumed record overwritten by a newer pair
module fetch_pair_tracker
    import fetch_pair_tracker_pkg::*;
#(
    parameter  int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_pair_tracker_if.slave   ir,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         outstanding,
    output logic [31:0]           pair_count,
    output logic                  err_overflow,
    output logic                  err_orphan,
    output logic                  err_drop
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } rec_t;

    logic                  addr_ev;
    logic                  data_ev;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] fifo_head;
    logic [CW-1:0]         fifo_count;

    rec_t                  rec_q, rec_d;
    logic                  valid_q, valid_d;
    logic [31:0]           pc_q, pc_d;
    logic                  ovf_q, ovf_d;
    logic                  orph_q, orph_d;
    logic                  drop_q, drop_d;

    assign addr_ev = ir.ir_addr_valid && ir.ir_addr_ready;
    assign data_ev = ir.ir_data_valid && ir.ir_data_ready;
    // Pairing uses occupancy at the start of the cycle, so a same-cycle
    // address can never satisfy a data beat.
    assign pop     = data_ev && !fifo_empty;

    sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (addr_ev),
        .push_data_i (ir.ir_addr),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        rec_d   = rec_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        orph_d  = orph_q;
        drop_d  = drop_q;

        if (pop) begin
            rec_d.addr = fifo_head;
            rec_d.data = ir.ir_data;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd1;
            // Replacing a record nobody has taken loses it.
            if (valid_q && !out_ready) drop_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (data_ev && fifo_empty)             orph_d = 1'b1;
        if (addr_ev && fifo_full && !pop)      ovf_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q   <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            ovf_q   <= 1'b0;
            orph_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            rec_q   <= rec_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            orph_q  <= orph_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_addr     = rec_q.addr;
    assign out_data     = rec_q.data;
    assign outstanding  = fifo_count;
    assign pair_count   = pc_q;
    assign err_overflow = ovf_q;
    assign err_orphan   = orph_q;
    assign err_drop     = drop_q;

endmodule

// File: tb/tb_fetch_pair_tracker.sv
// tb/tb_fetch_pair_tracker.sv - self-checking bench for fetch_pair_tracker
module tb_fetch_pair_tracker;
    import fetch_pair_tracker_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [CW-1:0] outstanding;
    logic [31:0]   pair_count;
    logic          err_overflow, err_orphan, err_drop;

    always #5 clk = ~clk;

    fetch_pair_tracker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_pair_tracker #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .outstanding  (outstanding),
        .pair_count   (pair_count),
        .err_overflow (err_overflow),
        .err_orphan   (err_orphan),
        .err_drop     (err_drop)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state and scoreboard.
    logic [AW-1:0]    m_addr_q [$];
    logic [AW+DW-1:0] exp_q [$];
    bit               m_valid, m_ovf, m_orph, m_drop;
    int unsigned      m_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_addr_q.delete();
        exp_q.delete();
        m_valid = 0; m_ovf = 0; m_orph = 0; m_drop = 0;
        m_pc = 0;
    endtask

    task automatic check_status();
        check("outstanding",  64'(outstanding),  64'(m_addr_q.size()));
        check("out_valid",    64'(out_valid),    64'(m_valid));
        check("pair_count",   64'(pair_count),   64'(m_pc));
        check("err_overflow", 64'(err_overflow), 64'(m_ovf));
        check("err_orphan",   64'(err_orphan),   64'(m_orph));
        check("err_drop",     64'(err_drop),     64'(m_drop));
    endtask

    // One bus cycle: drive events, predict, clock, then compare status.
    task automatic cycle(input bit av, input logic [AW-1:0] a,
                         input bit dv, input logic [DW-1:0] d, input bit ordy);
        logic [AW+DW-1:0] rec;
        bit               pop;
        bus.ir_addr_valid = av;
        bus.ir_addr_ready = 1'b1;
        bus.ir_addr       = a;
        bus.ir_data_valid = dv;
        bus.ir_data_ready = 1'b1;
        bus.ir_data       = d;
        out_ready         = ordy;

        // Record leaves at this edge: compare it against the scoreboard head.
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", 64'(out_addr), 64'hDEAD_0000_0000_0000);
            end else begin
                rec = exp_q.pop_front();
                check("rec_addr", 64'(out_addr), 64'(rec[AW+DW-1:DW]));
                check("rec_data", 64'(out_data), 64'(rec[DW-1:0]));
            end
        end

        pop = dv && (m_addr_q.size() > 0);
        if (dv && m_addr_q.size() == 0) m_orph = 1;
        if (pop) begin
            if (m_valid && !ordy) begin
                m_drop = 1;
                rec = exp_q.pop_front();
            end
            exp_q.push_back({m_addr_q.pop_front(), d});
            m_valid = 1;
            m_pc++;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        if (av) begin
            if (m_addr_q.size() < DEPTH) m_addr_q.push_back(a);
            else                         m_ovf = 1;
        end

        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset(input bit av, input bit dv);
        rst               = 1'b1;
        bus.ir_addr_valid = av;
        bus.ir_addr_ready = 1'b1;
        bus.ir_addr       = 32'hFFFF_0000;
        bus.ir_data_valid = dv;
        bus.ir_data_ready = 1'b1;
        bus.ir_data       = 32'h1234_5678;
        out_ready         = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check("rst_out_addr", 64'(out_addr), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check_status();
    endtask

    initial begin
        bus.ir_addr_valid = 1'b0;
        bus.ir_addr_ready = 1'b0;
        bus.ir_addr       = '0;
        bus.ir_data_valid = 1'b0;
        bus.ir_data_ready = 1'b0;
        bus.ir_data       = '0;
        model_clear();

        do_reset(0, 0);
        do_reset(0, 0);

        // Single fetch, data two cycles after the address.
        cycle(1, 32'h0000_0000, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 32'h0, 0);
        cycle(0, 32'h0, 1, 32'h0000_0013, 0);
        check("t1_out_addr", 64'(out_addr), 64'h0);
        check("t1_out_data", 64'(out_data), 64'h13);
        check("t1_pair_count", 64'(pair_count), 64'd1);
        cycle(0, 32'h0, 0, 32'h0, 1);

        // Four back-to-back addresses then four data beats, in order.
        for (int i = 0; i < 4; i++) cycle(1, 32'h100 + 32'(4 * i), 0, 32'h0, 1);
        check("t2_full", 64'(outstanding), 64'd4);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 32'hA000_0000 + 32'(i), 1);
        cycle(0, 32'h0, 0, 32'h0, 1);
        check("t2_empty", 64'(outstanding), 64'd0);

        // Overflow: fifth address is discarded and never appears.
        do_reset(0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 32'h300 + 32'(4 * i), 0, 32'h0, 1);
        check("t3_overflow", 64'(err_overflow), 64'd1);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 32'hB000_0000 + 32'(i), 1);
        cycle(0, 32'h0, 0, 32'h0, 1);

        // Orphan data with same-cycle address; next data pairs with it.
        do_reset(0, 0);
        cycle(1, 32'h200, 1, 32'h0000_00AA, 1);
        check("t4_orphan", 64'(err_orphan), 64'd1);
        check("t4_outstanding", 64'(outstanding), 64'd1);
        cycle(0, 32'h0, 1, 32'h0000_00BB, 1);
        check("t4_pair_addr", 64'(out_addr), 64'h200);
        cycle(0, 32'h0, 0, 32'h0, 1);

        // Overwrite while stalled: second pair wins, drop flagged.
        do_reset(0, 0);
        cycle(1, 32'h400, 0, 32'h0, 0);
        cycle(1, 32'h404, 0, 32'h0, 0);
        cycle(0, 32'h0, 1, 32'hC000_0001, 0);
        cycle(0, 32'h0, 1, 32'hC000_0002, 0);
        check("t5_drop", 64'(err_drop), 64'd1);
        check("t5_addr", 64'(out_addr), 64'h404);
        check("t5_data", 64'(out_data), 64'hC000_0002);
        check("t5_count", 64'(pair_count), 64'd2);
        cycle(0, 32'h0, 0, 32'h0, 1);

        // Full FIFO with simultaneous push and pop, then drain across the wrap.
        do_reset(0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h500 + 32'(4 * i), 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 32'h600 + 32'(4 * i), 1, 32'hD000_0000 + 32'(i), 1);
        check("t6_still_full", 64'(outstanding), 64'd4);
        check("t6_no_ovf", 64'(err_overflow), 64'd0);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 32'hE000_0000 + 32'(i), 1);
        cycle(0, 32'h0, 0, 32'h0, 1);

        // Reset mid-operation with events asserted in the reset cycle.
        do_reset(0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h700 + 32'(4 * i), 0, 32'h0, 0);
        cycle(0, 32'h0, 1, 32'hF000_0000, 0);
        check("t7_pre_outstanding", 64'(outstanding), 64'd3);
        check("t7_pre_valid", 64'(out_valid), 64'd1);
        do_reset(1, 1);
        cycle(0, 32'h0, 1, 32'hF000_0001, 1);
        check("t7_orphan", 64'(err_orphan), 64'd1);
        check("t7_no_record", 64'(out_valid), 64'd0);
        cycle(0, 32'h0, 0, 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pair_tracker.md
FETCH_PAIR_TRACKER -- requirements
Module: fetch_pair_tracker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction data width.
REQ-003 SHALL have parameter DEPTH, default 4, max outstanding fetch addresses (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ir_addr_valid, ir_addr_ready  input  1 each  snooped fetch-address handshake.
REQ-007 ir_addr  input  ADDR_WIDTH  snooped fetch address.
REQ-008 ir_data_valid, ir_data_ready  input  1 each  snooped fetch-data handshake.
REQ-009 ir_data  input  DATA_WIDTH  snooped fetch data.
REQ-010 out_valid  output  1  paired record available.
REQ-011 out_ready  input  1  consumer accepts record.
REQ-012 out_addr  output  ADDR_WIDTH  address of paired record.
REQ-013 out_data  output  DATA_WIDTH  data of paired record.
REQ-014 outstanding  output  $clog2(DEPTH)+1  addresses awaiting data.
REQ-015 pair_count  output  32  completed pairs since reset.
REQ-016 err_overflow, err_orphan, err_drop  output  1 each  sticky error flags.

Function
REQ-017 Block SHALL be passive: never drives ir_* signals, no effect on CPU bus.
REQ-018 Address event = ir_addr_valid&&ir_addr_ready; data event = ir_data_valid&&ir_data_ready.
REQ-019 Address event SHALL push ir_addr into an in-order address FIFO of DEPTH entries.
REQ-020 Data event with outstanding>0 (value at start of cycle) SHALL pop oldest address and load {out_addr,out_data} with {popped addr, ir_data}, out_valid=1, next cycle (1-cycle latency).
REQ-021 Data event with outstanding==0 SHALL set err_orphan, produce no record; a same-cycle address event is still pushed (no bypass).
REQ-022 Address event with outstanding==DEPTH and no same-cycle pop SHALL set err_overflow and discard the address.
REQ-023 Full FIFO with simultaneous push and pop SHALL accept both; outstanding unchanged.
REQ-024 outstanding SHALL be +1 push only, -1 pop only, unchanged for both/neither; never exceeds DEPTH or goes below 0.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH.
REQ-026 out_valid SHALL stay 1 with out_addr/out_data stable until out_valid&&out_ready.
REQ-027 New pair while out_valid=1 and out_ready=0 SHALL overwrite the record and set err_drop; with out_ready=1 same cycle, SHALL replace with no error.
REQ-028 pair_count SHALL increment by 1 per record loaded (incl. overwrites), wrapping at 2^32.
REQ-029 Error flags SHALL remain set until reset.

Reset
REQ-030 rst=1 at a clock edge SHALL zero out_valid, out_addr, out_data, outstanding, pair_count, all error flags, FIFO pointers.
REQ-031 rst asserted mid-operation SHALL discard all outstanding addresses and pending record; events in a reset cycle ignored.
REQ-032 First event accepted on first edge with rst=0.

Structure
REQ-033 Shared package SHALL hold fetch-record typedef {addr,data} and default width/depth constants.
REQ-034 Address FIFO SHALL be one sub-module, sync_fifo (push/pop/full/empty/count), reusable elsewhere.
REQ-035 No SV queues or dynamic constructs; synthesizable RTL only.

Verification
REQ-036 Addr 0x00000000, then data 0x00000013 two cycles later -> out_valid next cycle, out_addr 0x00000000, out_data 0x00000013, pair_count 1.
REQ-037 Addrs 0x100,0x104,0x108,0x10C back-to-back, then four data events -> records in order 0x100..0x10C, outstanding 4->0, no errors.
REQ-038 Five addrs with DEPTH=4, no data -> err_overflow=1, outstanding 4, fifth addr absent from later records.
REQ-039 Data event with empty FIFO and same-cycle addr 0x200 -> err_orphan=1, outstanding 1, next data pairs with 0x200.
REQ-040 out_ready=0, two pairs complete -> err_drop=1, record holds second pair, pair_count 2.
REQ-041 rst pulse with outstanding 3 and out_valid=1 -> all outputs 0 next cycle; subsequent data event raises err_orphan.
